// File: rtl/sierpinski_row_serializer_if.sv
// Bundle of the row input, control strobes and valid/ready serial stream
// between the Sierpinski row serializer and its neighbours.
interface sierpinski_row_serializer_if #(
    parameter int WIDTH = 14
);
    logic [WIDTH-1:0] row_in;
    logic             start;
    logic             abort;
    logic             ser_ready;
    logic             ser_valid;
    logic             ser_data;
    logic             ser_last;
    logic             row_done;
    logic             frame_done;
    logic             busy;
    logic [7:0]       row_count;

    // Driver side: generator/controller plus downstream ready.
    modport master (
        output row_in, start, abort, ser_ready,
        input  ser_valid, ser_data, ser_last, row_done, frame_done, busy, row_count
    );

    // Serializer side.
    modport slave (
        input  row_in, start, abort, ser_ready,
        output ser_valid, ser_data, ser_last, row_done, frame_done, busy, row_count
    );
endinterface

// File: rtl/sierpinski_row_serializer.sv
// Snapshots the free-running generator row on start (and after each idle gap)
// and shifts it out MSB-first on a valid/ready stream, ROWS rows per frame.
module sierpinski_row_serializer #(
    parameter int WIDTH = 14,
    parameter int ROWS  = 16,
    parameter int GAP   = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    sierpinski_row_serializer_if.slave  bus
);
    localparam int                 IDX_W    = $clog2(WIDTH);
    localparam int                 GAP_W    = $clog2(GAP + 1);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0]   GAP_INIT = GAP_W'(GAP - 1);
    localparam logic [7:0]         ROWS_C   = 8'(ROWS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q,     state_d;
    logic [WIDTH-1:0]   shift_q,     shift_d;
    logic [IDX_W-1:0]   bit_idx_q,   bit_idx_d;
    logic [GAP_W-1:0]   gap_cnt_q,   gap_cnt_d;
    logic [7:0]         row_count_q, row_count_d;

    logic               valid_s;
    logic               last_s;
    logic               xfer_s;
    logic [7:0]         row_inc_s;

    assign valid_s   = (state_q == ST_SHIFT);
    assign last_s    = valid_s & (bit_idx_q == LAST_IDX);
    assign xfer_s    = valid_s & bus.ser_ready;
    assign row_inc_s = row_count_q + 8'd1;

    // State and datapath registers; reset discards any row in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= {WIDTH{1'b0}};
            bit_idx_q   <= {IDX_W{1'b0}};
            gap_cnt_q   <= {GAP_W{1'b0}};
            row_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            gap_cnt_q   <= gap_cnt_d;
            row_count_q <= row_count_d;
        end
    end

    // Next-state logic: abort beats every other event, including a transfer.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        gap_cnt_d   = gap_cnt_q;
        row_count_d = row_count_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (bus.start) begin
                    state_d     = ST_SHIFT;
                    shift_d     = bus.row_in;
                    bit_idx_d   = {IDX_W{1'b0}};
                    row_count_d = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bus.abort) begin
                    state_d     = ST_IDLE;
                    row_count_d = 8'd0;
                end else if (xfer_s) begin
                    shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                    bit_idx_d = bit_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                    if (last_s) begin
                        row_count_d = row_inc_s;
                        if (row_inc_s == ROWS_C) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d   = ST_GAP;
                            gap_cnt_d = GAP_INIT;
                        end
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_GAP: begin
                if (bus.abort) begin
                    state_d     = ST_IDLE;
                    row_count_d = 8'd0;
                end else if (gap_cnt_q == {GAP_W{1'b0}}) begin
                    state_d   = ST_SHIFT;
                    shift_d   = bus.row_in;
                    bit_idx_d = {IDX_W{1'b0}};
                end else begin
                    gap_cnt_d = gap_cnt_q - {{(GAP_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                if (bus.abort) begin
                    row_count_d = 8'd0;
                end else begin
                    row_count_d = row_count_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.ser_valid  = valid_s;
    assign bus.ser_data   = valid_s & shift_q[WIDTH-1];
    assign bus.ser_last   = last_s;
    assign bus.row_done   = xfer_s & last_s & ~bus.abort;
    assign bus.frame_done = (state_q == ST_DONE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.row_count  = row_count_q;

endmodule
